// File: rtl/medidor_ultrassom_pkg.sv
// Shared definitions for the ultrasonic distance meter: FSM state codes,
// parameter defaults and a counter-width helper.
package medidor_ultrassom_pkg;

  localparam logic [2:0] INICIAL       = 3'd0;
  localparam logic [2:0] PREPARA       = 3'd1;
  localparam logic [2:0] ENVIA_TRIGGER = 3'd2;
  localparam logic [2:0] ESPERA_ECHO   = 3'd3;
  localparam logic [2:0] MEDE          = 3'd4;
  localparam logic [2:0] ARMAZENA      = 3'd5;
  localparam logic [2:0] FINAL         = 3'd6;

  localparam int TRIG_CICLOS_PADRAO    = 500;
  localparam int CICLOS_POR_CM_PADRAO  = 2941;
  localparam int TIMEOUT_CICLOS_PADRAO = 1500000;

  // Bits needed for a counter running 0..n-1 (never less than one bit).
  function automatic int largura(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/medidor_ultrassom_contador_bcd.sv
// Three-digit decimal up-counter that stops at 999 instead of wrapping.
module contador_bcd_3digitos (
  input  logic        clock,
  input  logic        reset,
  input  logic        limpa,
  input  logic        habilita,
  output logic [11:0] valor
);

  logic [3:0] u, d, c;

  assign u = valor[3:0];
  assign d = valor[7:4];
  assign c = valor[11:8];

  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      valor <= 12'h000;
    end else if (habilita && (valor != 12'h999)) begin
      if (u == 4'd9) begin
        valor[3:0] <= 4'd0;
        if (d == 4'd9) begin
          valor[7:4]  <= 4'd0;
          valor[11:8] <= c + 4'd1;
        end else begin
          valor[7:4] <= d + 4'd1;
        end
      end else begin
        valor[3:0] <= u + 4'd1;
      end
    end
  end

endmodule

// File: rtl/medidor_ultrassom.sv
// Ultrasonic ranger controller: fires a trigger pulse, times the echo and
// reports the distance in centimetres as three BCD digits.
module medidor_ultrassom
  import medidor_ultrassom_pkg::*;
#(
  parameter int TRIG_CICLOS    = TRIG_CICLOS_PADRAO,
  parameter int CICLOS_POR_CM  = CICLOS_POR_CM_PADRAO,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       echo,
  output logic       trigger,
  output logic [3:0] unidades,
  output logic [3:0] dezenas,
  output logic [3:0] centenas,
  output logic       pronto,
  output logic       erro,
  output logic [2:0] db_estado
);

  localparam int TW = largura(TRIG_CICLOS);
  localparam int CW = largura(CICLOS_POR_CM);
  localparam int OW = largura(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TRIG_FIM  = TW'(TRIG_CICLOS - 1);
  localparam logic [CW-1:0] CICLO_FIM = CW'(CICLOS_POR_CM - 1);
  localparam logic [OW-1:0] TMO_FIM   = OW'(TIMEOUT_CICLOS - 1);

  logic          echo_m, echo_s;
  logic [2:0]    estado, proximo;
  logic [TW-1:0] trig_cnt;
  logic [CW-1:0] ciclo_cnt;
  logic [OW-1:0] tmo_cnt;
  logic [11:0]   bcd;

  logic limpa, conta_trig, conta_tmo, conta_eco, carrega, seta_erro;
  logic trig_fim, ciclo_fim, tmo_fim;

  assign trig_fim  = (trig_cnt == TRIG_FIM);
  assign ciclo_fim = (ciclo_cnt == CICLO_FIM);
  assign tmo_fim   = (tmo_cnt == TMO_FIM);
  assign db_estado = estado;

  // The echo cycle that moves ESPERA_ECHO into MEDE is already counted,
  // so the total equals the number of cycles echo_s was high.
  always_comb begin
    proximo    = estado;
    limpa      = 1'b0;
    conta_trig = 1'b0;
    conta_tmo  = 1'b0;
    conta_eco  = 1'b0;
    carrega    = 1'b0;
    seta_erro  = 1'b0;
    case (estado)
      INICIAL:       if (medir) proximo = PREPARA;
      PREPARA: begin
        limpa   = 1'b1;
        proximo = ENVIA_TRIGGER;
      end
      ENVIA_TRIGGER: begin
        conta_trig = 1'b1;
        if (trig_fim) proximo = ESPERA_ECHO;
      end
      ESPERA_ECHO, MEDE: begin
        conta_tmo = 1'b1;
        conta_eco = echo_s;
        if (tmo_fim) begin
          seta_erro = 1'b1;
          proximo   = FINAL;
        end else if ((estado == ESPERA_ECHO) && echo_s) begin
          proximo = MEDE;
        end else if ((estado == MEDE) && !echo_s) begin
          proximo = ARMAZENA;
        end
      end
      ARMAZENA: begin
        carrega = 1'b1;
        proximo = FINAL;
      end
      FINAL:         proximo = INICIAL;
      default:       proximo = INICIAL;
    endcase
  end

  contador_bcd_3digitos u_bcd (
    .clock    (clock),
    .reset    (reset),
    .limpa    (limpa),
    .habilita (conta_eco && ciclo_fim),
    .valor    (bcd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      echo_m    <= 1'b0;
      echo_s    <= 1'b0;
      estado    <= INICIAL;
      trigger   <= 1'b0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
      trig_cnt  <= '0;
      ciclo_cnt <= '0;
      tmo_cnt   <= '0;
      unidades  <= 4'd0;
      dezenas   <= 4'd0;
      centenas  <= 4'd0;
    end else begin
      echo_m  <= echo;
      echo_s  <= echo_m;
      estado  <= proximo;
      trigger <= (proximo == ENVIA_TRIGGER);
      // Pronto is only raised on the ARMAZENA->FINAL path, never on timeout.
      pronto  <= carrega;

      if (limpa)           trig_cnt <= '0;
      else if (conta_trig) trig_cnt <= trig_cnt + 1'b1;

      if (limpa)          ciclo_cnt <= '0;
      else if (conta_eco) ciclo_cnt <= ciclo_fim ? '0 : ciclo_cnt + 1'b1;

      if (limpa)          tmo_cnt <= '0;
      else if (conta_tmo) tmo_cnt <= tmo_cnt + 1'b1;

      if (seta_erro)    erro <= 1'b1;
      else if (carrega) erro <= 1'b0;

      if (carrega) begin
        unidades <= bcd[3:0];
        dezenas  <= bcd[7:4];
        centenas <= bcd[11:8];
      end
    end
  end

endmodule

// File: tb/tb_medidor_ultrassom.sv
// Directed bench for medidor_ultrassom with scaled parameters
// (trigger 5 cycles, 2 cycles per cm, timeout 5000 cycles).
module tb_medidor_ultrassom;

  localparam int TRIG = 5;
  localparam int CPCM = 2;
  localparam int TMO  = 5000;

  logic       clock = 1'b0;
  logic       reset, medir, echo;
  logic       trigger, pronto, erro;
  logic [3:0] unidades, dezenas, centenas;
  logic [2:0] db_estado;

  int n_comp = 0;
  int n_fail = 0;
  int larg, np, cic;

  medidor_ultrassom #(
    .TRIG_CICLOS    (TRIG),
    .CICLOS_POR_CM  (CPCM),
    .TIMEOUT_CICLOS (TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .medir     (medir),
    .echo      (echo),
    .trigger   (trigger),
    .unidades  (unidades),
    .dezenas   (dezenas),
    .centenas  (centenas),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_comp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bcd_out();
    return {20'h0, centenas, dezenas, unidades};
  endfunction

  task automatic pulso_medir();
    @(negedge clock) medir = 1'b1;
    @(negedge clock) medir = 1'b0;
  endtask

  // Returns at the first negedge with trigger low after the pulse.
  task automatic espera_trigger(output int largura);
    int t;
    t = 0;
    largura = 0;
    while (trigger !== 1'b1 && t < 20) begin
      @(negedge clock);
      t++;
    end
    while (trigger === 1'b1 && largura < 100) begin
      @(negedge clock);
      largura++;
    end
  endtask

  task automatic eco(input int n);
    echo = 1'b1;
    repeat (n) @(negedge clock);
    echo = 1'b0;
  endtask

  // Runs until FINAL has been left; counts pronto samples and cycles to FINAL.
  task automatic espera_fim(input string tag, output int n_pronto, output int ciclos);
    bit saw;
    int t;
    saw = 0;
    n_pronto = 0;
    ciclos = 0;
    t = 0;
    while (t < 7000) begin
      @(negedge clock);
      t++;
      if (pronto === 1'b1) n_pronto++;
      if (db_estado === 3'd6) begin
        if (!saw) ciclos = t;
        saw = 1;
      end else if (saw) begin
        break;
      end
    end
    chk({tag, " reached FINAL"}, {31'h0, saw}, 32'h1);
  endtask

  task automatic medicao(input string tag, input int n_eco, input logic [11:0] esperado);
    pulso_medir();
    espera_trigger(larg);
    chk({tag, " trigger width"}, larg, TRIG);
    chk({tag, " waiting state"}, {29'h0, db_estado}, 32'd3);
    eco(n_eco);
    espera_fim(tag, np, cic);
    chk({tag, " bcd"}, bcd_out(), {20'h0, esperado});
    chk({tag, " pronto pulses"}, np, 1);
    chk({tag, " erro"}, {31'h0, erro}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    medir = 1'b0;
    echo  = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset estado", {29'h0, db_estado}, 32'd0);
    chk("reset trigger", {31'h0, trigger}, 32'h0);
    chk("reset pronto", {31'h0, pronto}, 32'h0);
    chk("reset erro", {31'h0, erro}, 32'h0);
    chk("reset bcd", bcd_out(), 32'h000);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle without medir", {29'h0, db_estado}, 32'd0);

    medicao("m31", 31, 12'h015);
    medicao("m29", 29, 12'h014);
    medicao("m1", 1, 12'h000);
    medicao("m2", 2, 12'h001);

    // Echo stuck high: timeout while in MEDE, outputs kept.
    pulso_medir();
    espera_trigger(larg);
    echo = 1'b1;
    repeat (10) @(negedge clock);
    chk("tmo mede state", {29'h0, db_estado}, 32'd4);
    espera_fim("tmo mede", np, cic);
    echo = 1'b0;
    chk("tmo mede cycles", cic, TMO - 10);
    chk("tmo mede erro", {31'h0, erro}, 32'h1);
    chk("tmo mede pronto", np, 0);
    chk("tmo mede bcd", bcd_out(), 32'h001);
    repeat (3) @(negedge clock);

    medicao("m60", 60, 12'h030);

    // medir during MEDE must not queue another measurement.
    pulso_medir();
    espera_trigger(larg);
    echo = 1'b1;
    repeat (10) @(negedge clock);
    chk("ign mede state", {29'h0, db_estado}, 32'd4);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    repeat (10) @(negedge clock);
    echo = 1'b0;
    espera_fim("ign", np, cic);
    chk("ign bcd", bcd_out(), 32'h010);
    chk("ign pronto", np, 1);
    repeat (5) @(negedge clock);
    chk("ign not queued", {29'h0, db_estado}, 32'd0);

    // Echo never rises.
    pulso_medir();
    espera_trigger(larg);
    espera_fim("tmo espera", np, cic);
    chk("tmo espera cycles", cic, TMO);
    chk("tmo espera erro", {31'h0, erro}, 32'h1);
    chk("tmo espera pronto", np, 0);
    chk("tmo espera bcd", bcd_out(), 32'h010);

    // Reset in the middle of MEDE.
    pulso_medir();
    espera_trigger(larg);
    echo = 1'b1;
    repeat (10) @(negedge clock);
    chk("rst mede state", {29'h0, db_estado}, 32'd4);
    reset = 1'b1;
    @(negedge clock);
    chk("rst estado", {29'h0, db_estado}, 32'd0);
    chk("rst trigger", {31'h0, trigger}, 32'h0);
    chk("rst bcd", bcd_out(), 32'h000);
    chk("rst erro", {31'h0, erro}, 32'h0);
    chk("rst pronto", {31'h0, pronto}, 32'h0);
    reset = 1'b0;
    echo  = 1'b0;
    repeat (4) @(negedge clock);
    chk("rst idle", {29'h0, db_estado}, 32'd0);

    // medir held high runs measurements back to back.
    @(negedge clock) medir = 1'b1;
    espera_trigger(larg);
    chk("b2b trigger1", larg, TRIG);
    eco(4);
    espera_fim("b2b1", np, cic);
    chk("b2b1 bcd", bcd_out(), 32'h002);
    chk("b2b1 pronto", np, 1);
    espera_trigger(larg);
    medir = 1'b0;
    chk("b2b trigger2", larg, TRIG);
    eco(6);
    espera_fim("b2b2", np, cic);
    chk("b2b2 bcd", bcd_out(), 32'h003);
    repeat (3) @(negedge clock);
    chk("b2b idle", {29'h0, db_estado}, 32'd0);

    // Saturation at 999.
    medicao("sat1996", 1996, 12'h998);
    medicao("sat2000", 2000, 12'h999);
    medicao("sat2010", 2010, 12'h999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
    $finish;
  end

endmodule

// File: doc/medidor_ultrassom.md
MEDIDOR_ULTRASSOM -- requirements
Module: medidor_ultrassom

Interface
REQ-001 SHALL have parameter TRIG_CICLOS, default 500, trigger pulse width in clock cycles (10 us at 50 MHz).
REQ-002 SHALL have parameter CICLOS_POR_CM, default 2941, echo cycles per centimetre (58.82 us at 50 MHz).
REQ-003 SHALL have parameter TIMEOUT_CICLOS, default 1500000, maximum cycles from ESPERA_ECHO entry to echo fall (30 ms).
REQ-004 SHALL have port: clock  in  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high.
REQ-006 SHALL have port: medir  in  1  start request, sampled only in INICIAL.
REQ-007 SHALL have port: echo  in  1  asynchronous sensor echo.
REQ-008 SHALL have port: trigger  out  1  registered sensor trigger.
REQ-009 SHALL have ports: unidades, dezenas, centenas  out  4 each  BCD distance in cm, feeding the floor converter.
REQ-010 SHALL have port: pronto  out  1  one-cycle pulse when a new valid distance is on the BCD outputs.
REQ-011 SHALL have port: erro  out  1  level, set on timeout, cleared by next valid measurement or reset.
REQ-012 SHALL have port: db_estado  out  3  current FSM state code.

Function
REQ-013 SHALL pass echo through a 2-flop synchroniser; all echo decisions use the synchronised value echo_s.
REQ-014 SHALL implement states INICIAL(0), PREPARA(1), ENVIA_TRIGGER(2), ESPERA_ECHO(3), MEDE(4), ARMAZENA(5), FINAL(6).
REQ-015 INICIAL: medir=1 -> PREPARA next cycle; else stay.
REQ-016 PREPARA: clear cycle counter, BCD counter and timeout counter; -> ENVIA_TRIGGER.
REQ-017 ENVIA_TRIGGER: trigger=1 for exactly TRIG_CICLOS cycles, then -> ESPERA_ECHO with trigger=0.
REQ-018 ESPERA_ECHO: echo_s=1 -> MEDE.
REQ-019 MEDE: each cycle with echo_s=1 increments the cycle counter; at CICLOS_POR_CM-1 it wraps to 0 and the BCD counter increments (distance = floor(high cycles / CICLOS_POR_CM)).
REQ-020 MEDE: echo_s=0 -> ARMAZENA.
REQ-021 BCD counter SHALL carry units->tens->hundreds in decimal and saturate at 999 (no wrap).
REQ-022 ARMAZENA: copy BCD counter to unidades/dezenas/centenas, clear erro; -> FINAL.
REQ-023 FINAL: pronto=1 for this cycle only if entered from ARMAZENA; -> INICIAL.
REQ-024 Timeout counter SHALL run in ESPERA_ECHO and MEDE; on reaching TIMEOUT_CICLOS -> FINAL with erro=1, BCD outputs unchanged, no pronto.
REQ-025 medir asserted outside INICIAL SHALL be ignored (not queued); medir held high SHALL start back-to-back measurements.
REQ-026 BCD outputs SHALL hold the last valid measurement between measurements and on timeout.

Reset
REQ-027 reset=1 at a clock edge SHALL force INICIAL, trigger=0, pronto=0, erro=0, BCD outputs 0, all counters and synchroniser flops 0, taking priority over every other event including mid-measurement.

Structure
REQ-028 State codes and parameter defaults SHALL live in the shared project package.
REQ-029 The 3-digit saturating BCD counter (clear, enable, 12-bit output) SHALL be a sub-module named contador_bcd_3digitos.
REQ-030 Datapath and FSM SHALL be separated: FSM drives clear/enable/load signals only.

Verification
REQ-031 medir pulse, echo high 44115 cycles -> trigger high 500 cycles, then centenas/dezenas/unidades = 0/1/5, pronto one cycle, erro=0.
REQ-032 Echo high 44114 cycles -> 0/1/4 (floor boundary); echo high 2941 -> 0/0/1; echo high 2940 -> 0/0/0.
REQ-033 Echo never rises after trigger -> erro=1 after 1500000 cycles in ESPERA_ECHO+MEDE, BCD outputs keep prior value, no pronto.
REQ-034 Echo high 3000000 cycles -> timeout in MEDE, erro=1; following 30 cm measurement (88230 cycles) -> 0/3/0, erro=0.
REQ-035 reset asserted during MEDE -> next edge db_estado=0, trigger=0, outputs 0/0/0; medir during MEDE ignored.
REQ-036 Parameter override CICLOS_POR_CM=2, TIMEOUT_CICLOS=5000, echo high 2000 cycles -> saturation at 9/9/9.
